pb_event_decoder: RTL and testbench

Converts the clean, synchronous `pb_debounced` level from the push-button debouncer into discrete button events: a one-cycle press pulse, a release pulse, a long-press pulse, optional auto-repeat pulses, and a wrapping mode index. It sits directly downstream of the debouncer, on the same clock, and feeds mode-select and display logic.

---
 rtl/pb_event_pkg.sv | 15 +
 rtl/pb_hold_timer.sv | 30 +++
 rtl/pb_event_decoder.sv | 146 ++++++++++++++
 tb/tb_pb_event_decoder.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pb_event_pkg.sv
// Shared types and default parameters for the push-button event decoder.
package pb_event_pkg;

  typedef enum logic [1:0] {
    ST_LOCK    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_LONG    = 2'd3
  } pb_state_e;

  localparam int DEF_LONG_CYCLES   = 200;
  localparam int DEF_REPEAT_CYCLES = 25;
  localparam int DEF_MODE_NUM      = 4;

endpackage

// File: rtl/pb_hold_timer.sv
// Terminal-count counter: o_done strobes while enabled at TERMINAL-1, and the count
// then restarts from 0. i_clr holds the count at 0.
module pb_hold_timer
  import pb_event_pkg::*;
#(
  parameter int TERMINAL = DEF_LONG_CYCLES,
  parameter int CNT_W    = $clog2(DEF_LONG_CYCLES)
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);

  logic [CNT_W-1:0] r_cnt;
  logic             w_at_term;

  assign w_at_term = (r_cnt == CNT_W'(TERMINAL - 1));
  assign o_done    = i_en && w_at_term;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_at_term ? '0 : r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/pb_event_decoder.sv
// Turns a debounced button level into press/release/long/repeat pulses and a mode index.
// Auto-repeat while held long is compiled in with `define PB_AUTOREPEAT_EN.
module pb_event_decoder
  import pb_event_pkg::*;
#(
  parameter int  LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int  REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int  MODE_NUM      = DEF_MODE_NUM,
  localparam int MODE_W        = $clog2(MODE_NUM)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pb_debounced,
  output logic              press_pulse,
  output logic              release_pulse,
  output logic              long_pulse,
  output logic              repeat_pulse,
  output logic              held,
  output logic [MODE_W-1:0] mode
);

  localparam int HOLD_W = $clog2(LONG_CYCLES);

  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("LONG_CYCLES must be at least 2");
  end
  if (REPEAT_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_CYCLES must be at least 1");
  end
  if (MODE_NUM < 2) begin : g_bad_mode
    $error("MODE_NUM must be at least 2");
  end

  pb_state_e         r_state, w_state_next;
  logic              r_press, r_release, r_long, r_held;
  logic              w_press_next, w_release_next, w_long_next;
  logic [MODE_W-1:0] r_mode, w_mode_next;
  logic              w_hold_done;
  logic              w_rep_done;

  function automatic logic [MODE_W-1:0] f_mode_inc(input logic [MODE_W-1:0] m);
    return (m == MODE_W'(MODE_NUM - 1)) ? '0 : m + MODE_W'(1);
  endfunction

  // Counters only run in their own state; outside it they are held cleared.
  pb_hold_timer #(.TERMINAL(LONG_CYCLES), .CNT_W(HOLD_W)) u_hold_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state != ST_PRESSED),
    .i_en   ((r_state == ST_PRESSED) && pb_debounced),
    .o_done (w_hold_done)
  );

`ifdef PB_AUTOREPEAT_EN
  localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
  logic r_repeat, w_repeat_next;

  pb_hold_timer #(.TERMINAL(REPEAT_CYCLES), .CNT_W(REP_W)) u_rep_timer (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (r_state != ST_LONG),
    .i_en   ((r_state == ST_LONG) && pb_debounced),
    .o_done (w_rep_done)
  );

  always_ff @(posedge clk) begin
    if (rst) r_repeat <= 1'b0;
    else     r_repeat <= w_repeat_next;
  end

  assign repeat_pulse = r_repeat;
`else
  assign w_rep_done   = 1'b0;
  assign repeat_pulse = 1'b0;
`endif

  // Release is tested first in every held state so it always wins over a terminal count.
  always_comb begin
    w_state_next   = r_state;
    w_press_next   = 1'b0;
    w_release_next = 1'b0;
    w_long_next    = 1'b0;
    w_mode_next    = r_mode;
`ifdef PB_AUTOREPEAT_EN
    w_repeat_next  = 1'b0;
`endif
    case (r_state)
      ST_LOCK: begin
        if (!pb_debounced) w_state_next = ST_IDLE;
      end
      ST_IDLE: begin
        if (pb_debounced) begin
          w_state_next = ST_PRESSED;
          w_press_next = 1'b1;
        end
      end
      ST_PRESSED: begin
        if (!pb_debounced) begin
          w_state_next   = ST_IDLE;
          w_release_next = 1'b1;
          w_mode_next    = f_mode_inc(r_mode);
        end else if (w_hold_done) begin
          w_state_next = ST_LONG;
          w_long_next  = 1'b1;
        end
      end
      ST_LONG: begin
        if (!pb_debounced) begin
          w_state_next   = ST_IDLE;
          w_release_next = 1'b1;
        end else if (w_rep_done) begin
`ifdef PB_AUTOREPEAT_EN
          w_repeat_next = 1'b1;
`endif
          w_mode_next   = f_mode_inc(r_mode);
        end
      end
      default: w_state_next = ST_LOCK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_LOCK;
      r_press   <= 1'b0;
      r_release <= 1'b0;
      r_long    <= 1'b0;
      r_held    <= 1'b0;
      r_mode    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_press   <= w_press_next;
      r_release <= w_release_next;
      r_long    <= w_long_next;
      r_held    <= (w_state_next == ST_PRESSED) || (w_state_next == ST_LONG);
      r_mode    <= w_mode_next;
    end
  end

  assign press_pulse   = r_press;
  assign release_pulse = r_release;
  assign long_pulse    = r_long;
  assign held          = r_held;
  assign mode          = r_mode;

endmodule

// File: tb/tb_pb_event_decoder.sv
// Scoreboard bench: each press is described by its hold length; the expected event
// sequence is derived from that length and compared by a free-running monitor.
module tb_pb_event_decoder;

  localparam int L = 8;
  localparam int R = 3;
  localparam int M = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pb_debounced = 1'b1;
  logic       press_pulse, release_pulse, long_pulse, repeat_pulse, held;
  logic [1:0] mode;

  pb_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .MODE_NUM(M)) dut (
    .clk           (clk),
    .rst           (rst),
    .pb_debounced  (pb_debounced),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .repeat_pulse  (repeat_pulse),
    .held          (held),
    .mode          (mode)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       cyc;
    logic [3:0] kind;   // {press, release, long, repeat}
    logic     hld;
    int       md;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  edge_cnt = 0;
  int  checks   = 0;
  int  failures = 0;
  int  model_mode = 0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Monitor: every observed pulse must match the oldest expected event, and any
  // expected event whose cycle has passed unobserved is reported as missed.
  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < edge_cnt) begin
        mon_e = exp_q.pop_front();
        checks++;
        failures++;
        $display("FAIL missed_event: got nothing at cycle %0d, required kind=%b mode=%0d",
                 mon_e.cyc, mon_e.kind, mon_e.md);
      end
      if (press_pulse || release_pulse || long_pulse || repeat_pulse) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: got kind=%b mode=%0d at cycle %0d, required none",
                   {press_pulse, release_pulse, long_pulse, repeat_pulse}, mode, edge_cnt);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e.cyc != edge_cnt ||
              mon_e.kind != {press_pulse, release_pulse, long_pulse, repeat_pulse} ||
              mon_e.hld != held || mon_e.md != int'(mode)) begin
            failures++;
            $display("FAIL event: got cyc=%0d kind=%b held=%b mode=%0d, required cyc=%0d kind=%b held=%b mode=%0d",
                     edge_cnt, {press_pulse, release_pulse, long_pulse, repeat_pulse}, held, mode,
                     mon_e.cyc, mon_e.kind, mon_e.hld, mon_e.md);
          end else begin
            $display("event ok: cyc=%0d kind=%b mode=%0d", edge_cnt,
                     {press_pulse, release_pulse, long_pulse, repeat_pulse}, mode);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end else begin
      $display("check ok: %s = %0d", name, act);
    end
  endtask

  task automatic push_ev(input int c, input logic [3:0] k, input logic h, input int m);
    ev_t e;
    e.cyc = c; e.kind = k; e.hld = h; e.md = m;
    exp_q.push_back(e);
  endtask

  // Called just after a rising edge; holds the level for n sampling edges.
  task automatic drive(input logic v, input int n);
    repeat (n) begin
      pb_debounced = v;
      @(posedge clk);
      #1;
    end
  endtask

  // A press sampled high on h consecutive edges starting at k, then low for g edges.
  task automatic press_seg(input int h, input int g);
    int k;
    k = edge_cnt + 1;
    push_ev(k, 4'b1000, 1'b1, model_mode);
    if (h > L) begin
      push_ev(k + L, 4'b0010, 1'b1, model_mode);
`ifdef PB_AUTOREPEAT_EN
      for (int n = 1; L + R * n < h; n++) begin
        model_mode = (model_mode + 1) % M;
        push_ev(k + L + R * n, 4'b0001, 1'b1, model_mode);
      end
`endif
    end else begin
      model_mode = (model_mode + 1) % M;
    end
    push_ev(k + h, 4'b0100, 1'b0, model_mode);
    drive(1'b1, h);
    drive(1'b0, g);
  endtask

  initial begin
    int k;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", int'({press_pulse, release_pulse, long_pulse, repeat_pulse, held, mode}), 0);

    // Button held through reset: no events until it is released.
    rst = 1'b0;
    drive(1'b1, 10);
    chk("lock_held", int'(held), 0);
    drive(1'b0, 2);
    chk("lock_mode", int'(mode), 0);

    // Four short presses wrap the mode back to 0.
    for (int i = 0; i < 4; i++) press_seg(5, 3);
    chk("mode_wrap", int'(mode), 0);

    press_seg(20, 3);
    chk("mode_after_long", int'(mode), model_mode);
    press_seg(L, 3);
    press_seg(L + 1, 2);
    press_seg(1, 1);
    press_seg(L - 1, 1);

    for (int i = 0; i < 40; i++) press_seg(int'($urandom_range(1, 30)), int'($urandom_range(1, 4)));
    chk("mode_after_random", int'(mode), model_mode);

    // Reset in the middle of a press: no release, outputs reset, LOCK until released.
    k = edge_cnt + 1;
    push_ev(k, 4'b1000, 1'b1, model_mode);
    drive(1'b1, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_mode = 0;
    chk("midpress_reset_outputs",
        int'({press_pulse, release_pulse, long_pulse, repeat_pulse, held, mode}), 0);
    drive(1'b1, 6);
    chk("midpress_lock_held", int'(held), 0);
    drive(1'b0, 2);
    press_seg(3, 2);
    chk("mode_after_reset_press", int'(mode), 1);

    drive(1'b0, 5);
    chk("queue_drained", exp_q.size(), 0);
    chk("final_held", int'(held), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
